// File: rtl/cla_pipe_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_pkg : shared op encodings and configuration helpers for the          |
// |           pipelined carry-lookahead adder.           Revision: 1.0       |
// +--------------------------------------------------------------------------+
package cla_pkg;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_pipe_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_pipe_adder_if : operand/result streaming bundle with valid/ready.   |
// |                                                      Revision: 1.0       |
// +--------------------------------------------------------------------------+
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_signed, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, in_signed, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/cla_pipe_adder_chunk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_chunk : combinational CW-bit carry-lookahead adder slice with group  |
// |             propagate/generate outputs.              Revision: 1.0       |
// +--------------------------------------------------------------------------+
module cla_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          cmsb,
  output logic          P,
  output logic          G
);
  logic [CW-1:0] w_p;
  logic [CW-1:0] w_g;
  logic [CW:0]   w_c;
  logic          w_t;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every carry is a flat sum of generate terms, never a chain through c[i].
  always_comb begin
    w_c    = '0;
    w_t    = 1'b0;
    G      = 1'b0;
    w_c[0] = cin;
    for (int i = 0; i < CW; i++) begin
      w_c[i+1] = cin;
      for (int j = 0; j <= i; j++) w_c[i+1] = w_c[i+1] & w_p[j];
      for (int j = 0; j <= i; j++) begin
        w_t = w_g[j];
        for (int m = j + 1; m <= i; m++) w_t = w_t & w_p[m];
        w_c[i+1] = w_c[i+1] | w_t;
      end
    end
    for (int j = 0; j < CW; j++) begin
      w_t = w_g[j];
      for (int m = j + 1; m < CW; m++) w_t = w_t & w_p[m];
      G = G | w_t;
    end
  end

  assign P    = &w_p;
  assign sum  = w_p ^ w_c[CW-1:0];
  assign cout = w_c[CW];
  assign cmsb = w_c[CW-1];
endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_pipe_adder : STAGES-deep pipelined CLA adder/subtractor, one chunk   |
// |   per clock. Define CLA_PIPE_SAT_EN for saturating results.             |
// |                                                      Revision: 1.0       |
// +--------------------------------------------------------------------------+
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_a    [STAGES];
  logic [WIDTH-1:0] w_b    [STAGES];
  logic [WIDTH-1:0] w_acc  [STAGES];
  logic [CW-1:0]    w_csum [STAGES];
  logic             w_cin  [STAGES];
  logic             w_sgn  [STAGES];
  logic             w_vld  [STAGES];
  logic             w_cout [STAGES];
  logic             w_cmsb [STAGES];
  logic             w_p    [STAGES];
  logic             w_g    [STAGES];

  logic [WIDTH-1:0] r_a    [STAGES];
  logic [WIDTH-1:0] r_b    [STAGES];
  logic [WIDTH-1:0] r_acc  [STAGES];
  logic             r_c    [STAGES];
  logic             r_sgn  [STAGES];
  logic             r_vld  [STAGES];
`ifdef CLA_PIPE_SAT_EN
  alu_op_e          w_op   [STAGES];
  alu_op_e          r_op   [STAGES];
`endif

  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_a[k]   = bus.in_a;
      assign w_b[k]   = bus.in_b ^ {WIDTH{bus.in_sub}};
      assign w_cin[k] = bus.in_sub;
      assign w_acc[k] = '0;
      assign w_sgn[k] = bus.in_signed;
      assign w_vld[k] = bus.in_valid;
`ifdef CLA_PIPE_SAT_EN
      assign w_op[k]  = bus.in_sub ? ALU_SUB : ALU_ADD;
`endif
    end else begin : g_body
      assign w_a[k]   = r_a[k-1];
      assign w_b[k]   = r_b[k-1];
      assign w_cin[k] = r_c[k-1];
      assign w_acc[k] = r_acc[k-1];
      assign w_sgn[k] = r_sgn[k-1];
      assign w_vld[k] = r_vld[k-1];
`ifdef CLA_PIPE_SAT_EN
      assign w_op[k]  = r_op[k-1];
`endif
    end

    cla_chunk #(.CW(CW)) u_chunk (
      .a    (w_a[k][k*CW +: CW]),
      .b    (w_b[k][k*CW +: CW]),
      .cin  (w_cin[k]),
      .sum  (w_csum[k]),
      .cout (w_cout[k]),
      .cmsb (w_cmsb[k]),
      .P    (w_p[k]),
      .G    (w_g[k])
    );

    if (k < STAGES - 1) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld[k] <= 1'b0;
          r_a[k]   <= '0;
          r_b[k]   <= '0;
          r_acc[k] <= '0;
          r_c[k]   <= 1'b0;
          r_sgn[k] <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
          r_op[k]  <= ALU_ADD;
`endif
        end else if (w_adv) begin
          r_vld[k] <= w_vld[k];
          r_a[k]   <= w_a[k];
          r_b[k]   <= w_b[k];
          r_acc[k] <= w_acc[k] | (WIDTH'(w_csum[k]) << (k * CW));
          r_c[k]   <= w_g[k] | (w_p[k] & w_cin[k]);
          r_sgn[k] <= w_sgn[k];
`ifdef CLA_PIPE_SAT_EN
          r_op[k]  <= w_op[k];
`endif
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] w_raw;
      logic [WIDTH-1:0] w_res;
      logic             w_ovf;

      assign w_raw = w_acc[k] | (WIDTH'(w_csum[k]) << (k * CW));
      assign w_ovf = w_sgn[k] & (w_cmsb[k] ^ w_cout[k]);

`ifdef CLA_PIPE_SAT_EN
      // Signed clamp direction follows A's sign; overflow only occurs away from it.
      always_comb begin
        w_res = w_raw;
        if (w_sgn[k]) begin
          if (w_ovf) w_res = {w_a[k][WIDTH-1], {(WIDTH-1){!w_a[k][WIDTH-1]}}};
        end else if (w_op[k] == ALU_ADD && w_cout[k]) begin
          w_res = '1;
        end else if (w_op[k] == ALU_SUB && !w_cout[k]) begin
          w_res = '0;
        end
      end
`else
      assign w_res = w_raw;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bus.out_valid <= 1'b0;
          bus.out_sum   <= '0;
          bus.out_cout  <= 1'b0;
          bus.out_ovf   <= 1'b0;
          bus.out_zero  <= 1'b0;
        end else if (w_adv) begin
          bus.out_valid <= w_vld[k];
          bus.out_sum   <= w_res;
          bus.out_cout  <= w_cout[k];
          bus.out_ovf   <= w_ovf;
          bus.out_zero  <= (w_res == '0);
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cla_pipe_adder : directed + randomized bench for cla_pipe_adder with  |
// |   an arithmetic reference model and a STAGES sweep.  Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    res_t r;
    int   stamp;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  cla_pipe_adder_if #(.WIDTH(16)) bus ();

  cla_pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic sgn);
    res_t r;
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sb : sa + sb;
    r.sum  = ur[15:0];
    r.cout = sub ? (ua >= ub) : (ur > 65535);
    r.ovf  = sgn && (sr > 32767 || sr < -32768);
`ifdef CLA_PIPE_SAT_EN
    if (sgn) begin
      if (sr > 32767) r.sum = 16'h7FFF;
      else if (sr < -32768) r.sum = 16'h8000;
    end else begin
      if (ur > 65535) r.sum = 16'hFFFF;
      else if (ur < 0) r.sum = 16'h0000;
    end
`endif
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk_res(input string tag, input res_t obs, input res_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
             tag, obs.sum, obs.cout, obs.ovf, obs.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t obs_main();
    return {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero};
  endfunction

  // Scoreboard and hold-stability monitor for the main DUT.
  res_t q[$];
  logic held;
  res_t held_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held <= 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk_res("stall_stable", obs_main(), held_r);
      end
      held   <= bus.out_valid && !bus.out_ready;
      held_r <= obs_main();
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          chk_res("sb_result", obs_main(), q[0]);
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.in_a, bus.in_b, bus.in_sub, bus.in_signed));
    end
  end

  // STAGES sweep: same operand stream, no backpressure, exact latency check.
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int NST = (g < 2) ? (1 << g) : (1 << (g + 1));
    cla_pipe_adder_if #(.WIDTH(16)) sb ();
    ent_t sq[$];

    assign sb.in_valid  = bus.in_valid;
    assign sb.in_a      = bus.in_a;
    assign sb.in_b      = bus.in_b;
    assign sb.in_sub    = bus.in_sub;
    assign sb.in_signed = bus.in_signed;
    assign sb.out_ready = 1'b1;

    cla_pipe_adder #(.WIDTH(16), .STAGES(NST)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sb)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        sq.delete();
      end else begin
        if (sb.out_valid) begin
          chk($sformatf("sweep%0d_nonempty", NST), 32'(sq.size() != 0), 32'd1);
          if (sq.size() != 0) begin
            chk_res($sformatf("sweep%0d_result", NST),
                    {sb.out_sum, sb.out_cout, sb.out_ovf, sb.out_zero}, sq[0].r);
            chk($sformatf("sweep%0d_latency", NST), 32'(cyc - sq[0].stamp), 32'(NST));
            void'(sq.pop_front());
          end
        end
        if (sb.in_valid && sb.in_ready)
          sq.push_back({model(sb.in_a, sb.in_b, sb.in_sub, sb.in_signed), cyc});
      end
    end
  end

  task automatic run_dir(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic sgn, input res_t exp);
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sub    = sub;
    bus.in_signed = sgn;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk_res(tag, obs_main(), exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int   i, k, sent, seen_valid;
    logic acc, saw_stall;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_res("reset_outputs", obs_main(), '0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    run_dir("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0, 1'b0});
    run_dir("sub_equal", 16'h1234, 16'h1234, 1'b1, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});
`ifdef CLA_PIPE_SAT_EN
    run_dir("sub_sovf", 16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b0});
    run_dir("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'hFFFF, 1'b1, 1'b0, 1'b0});
    run_dir("sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, {16'h0000, 1'b0, 1'b0, 1'b1});
    run_dir("add_sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b0, 1'b1, 1'b0});
`else
    run_dir("sub_sovf", 16'h8000, 16'h0001, 1'b1, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0});
    run_dir("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
    run_dir("sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, {16'hFFFF, 1'b0, 1'b0, 1'b0});
    run_dir("add_sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h8000, 1'b0, 1'b1, 1'b0});
`endif

    // Eight back-to-back beats with the sink stalled on cycles 5..7.
    i = 0;
    k = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      bus.in_valid  = (i < 8);
      bus.in_a      = 16'(i);
      bus.in_b      = 16'(3 * i);
      bus.in_sub    = 1'b0;
      bus.in_signed = 1'b0;
      bus.out_ready = !(c >= 5 && c <= 7);
      @(negedge clk);
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        saw_stall = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("stream_order", 32'(bus.out_sum), 32'(4 * k));
        k++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", 32'(k), 32'd8);
    chk("stream_stalled", 32'(saw_stall), 32'd1);

    // Reset with three beats in flight.
    for (int n = 1; n <= 3; n++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'(n * 1000);
      bus.in_b     = 16'(n);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_res("async_reset_outputs", obs_main(), '0);
    chk("async_reset_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid++;
    end
    chk("no_stale_valid", 32'(seen_valid), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure.
    sent = 0;
    acc  = 1'b0;
    for (int n = 0; n < 5000 && sent < 1000; n++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.in_a      = rnd16();
        bus.in_b      = rnd16();
        bus.in_sub    = 1'($urandom_range(0, 1));
        bus.in_signed = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) sent++;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("random_sent", 32'(sent), 32'd1000);
    chk("random_drained", 32'(q.size()), 32'd0);
    chk("random_idle", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 16-bit combinational CLA.
- Operand width is split into STAGES chunks; one chunk is resolved per clock, with the carry registered between stages.
- Streaming valid/ready handshake on input and output, with backpressure.
- Used in the execute stage and the address-generation path when WIDTH exceeds single-cycle timing.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; legal range 1..WIDTH.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_sub  input  1  1 = A-B (B inverted, carry-in 1); 0 = A+B
in_signed  input  1  1 = two's-complement interpretation for ovf (and saturation)
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  result
out_cout  output  1  carry out of MSB (for sub: 1 = no borrow)
out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB; 0 when in_signed=0
out_zero  output  1  out_sum == 0

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0; out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0. in_ready=1 after reset release.
- Datapath:
  - Stage k (0..STAGES-1) computes chunk k bits [k*CW +: CW] with a CW-bit CLA, using the carry registered from stage k-1.
  - Stage 0 uses carry-in = in_sub.
  - Upper chunks of A and (B XOR {WIDTH{in_sub}}) travel skewed through registers; lower sum chunks travel de-skewed, so out_sum is assembled aligned.
- Latency: STAGES cycles from accept (in_valid & in_ready) to out_valid, with no backpressure.
- Throughput: one result per clock.
- Advance rule: adv = !out_valid | out_ready. All stage registers shift together when adv=1 and hold when adv=0. in_ready = adv (combinational from out_ready).
- Bubbles: invalid slots propagate as valid=0. Data registers may load but must not be observed.
- Output stability: while out_valid=1 and out_ready=0, out_sum/cout/ovf/zero/out_valid hold constant.
- Accepted beats are never dropped or duplicated; order is preserved.
- out_ovf uses the carry into the MSB, captured in the final stage.
- out_zero is computed from the final assembled sum, registered together with it.
- STAGES=1: degenerates to a single registered WIDTH-bit CLA with latency 1.
- Mid-operation reset: all in-flight beats are discarded; no out_valid pulse after release until a new accept.
- Wrap-around: unsigned results are modulo 2^WIDTH (unless the optional feature is enabled); out_cout flags the wrap.

Optional Feature:
CLA_PIPE_SAT_EN
- Defined: saturating result, selected by in_signed.
  - in_signed=1 and out_ovf=1: out_sum clamps to the signed max (0x7FFF at WIDTH=16) or min (0x8000), chosen by the sign of A.
  - in_signed=0: add with cout=1 clamps to all-ones; sub with cout=0 (borrow) clamps to 0.
  - Clamp is applied in the final stage; no added latency.
  - out_cout and out_ovf still report the raw, unsaturated flags. out_zero reflects the clamped sum.
- Undefined: wrap-around only; no clamp logic is synthesised.

Decomposition:
- Package cla_pkg: ALU_ADD/ALU_SUB op encodings; function chunk_width(WIDTH, STAGES); elaboration check that WIDTH % STAGES == 0.
- Sub-module cla_chunk: combinational CW-bit lookahead adder with ports a, b, cin, sum, cout, cmsb (carry into MSB), P, G. Instantiated once per stage via generate.
- Top level holds the skew/de-skew registers, valid chain and flag logic.

Test Plan:
- WIDTH=16, STAGES=4, add 0x00FF+0x0001, out_ready=1 -> after exactly 4 cycles: sum=0x0100, cout=0, ovf=0, zero=0.
- Sub 0x8000-0x0001, in_signed=1 -> sum=0x7FFF, ovf=1, cout=1. With CLA_PIPE_SAT_EN -> sum=0x8000, ovf=1.
- Add 0xFFFF+0x0001, unsigned -> sum=0x0000, cout=1, zero=1. With CLA_PIPE_SAT_EN -> sum=0xFFFF, zero=0.
- Stream 8 back-to-back beats (A=i, B=i*3), holding out_ready=0 on cycles 5-7:
  - in_ready drops while the output is full and unread.
  - All 8 results (4*i) emerge in order, with no loss or duplication.
  - Outputs stay stable while stalled.
- Assert rst_n low mid-stream with 3 beats in flight -> all outputs 0 immediately (asynchronously); no stale out_valid after release.
- Parameter sweep STAGES in {1,2,8,16} at WIDTH=16 with 1000 random add/sub beats -> matches reference model; latency == STAGES.
